spi_mem_sequencer: RTL
======================

# spi_mem_sequencer

Transaction sequencer for the SPI memory datapath. It watches the conditioned chip-select, SCLK edge strobes and shift-register parallel output, decodes the command byte (7-bit address plus R/W), and owns the memory address register. It drives the shift-register load strobe, the data-memory write strobe and the MISO buffer enable. It replaces the ad-hoc control FSM and address latch, and adds reset, abort handling and optional burst addressing.

## Interface
- ADDR_W, 7, memory address width
- DATA_W, 8, data width; the command byte is DATA_W bits
- clk  in  1  FPGA clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  conditioned chip select, active low
- sclk_rise  in  1  one-clk pulse on each conditioned SCLK rising edge
- sclk_fall  in  1  one-clk pulse on each conditioned SCLK falling edge; used only for MISO release
- sr_pdata  in  DATA_W  shift-register parallel output
- addr  out  ADDR_W  memory address
- sr_we  out  1  one-clk parallel-load strobe to the shift register
- dm_we  out  1  one-clk write strobe to data memory
- miso_buf  out  1  MISO tristate enable
- busy  out  1  high whenever state is not IDLE
- state  out  4  current state encoding, for LEDs

## Operation
- States: IDLE, CMD, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE.
- The 3-bit bit counter cnt increments on sclk_rise in CMD, RD_SHIFT and WR_SHIFT. The count wraps 7→0, and that wrap marks the byte boundary.
- IDLE → CMD when cs is low. cnt clears on entry.
- CMD → LATCH on the 8th sclk_rise.
- In LATCH (one clk):
  - addr ← sr_pdata[7:1] and rw ← sr_pdata[0].
  - Next state is RD_WAIT if rw=1, otherwise WR_SHIFT.
- RD_WAIT lasts one clk and allows for the synchronous memory read. It → RD_LOAD.
- RD_LOAD: sr_we=1 for one clk, then → RD_SHIFT.
- miso_buf=1 from RD_LOAD through RD_SHIFT.
- RD_SHIFT → DONE on the 8th sclk_rise. miso_buf stays high until the next sclk_fall, so the last bit is held for the master.
- WR_SHIFT → WR_COMMIT on the 8th sclk_rise.
- WR_COMMIT: dm_we=1 for one clk with addr stable, then → DONE.
- DONE: all strobes low and sclk is ignored. It → IDLE when cs goes high.
- Abort: cs high in any state forces IDLE on the next clk.
  - All strobes drop to 0 and cnt clears.
  - A partial write byte is never committed. If cs rises in the same clk as the WR_COMMIT entry, dm_we is suppressed.
- Simultaneous events: cs high has priority over sclk_rise.
- sr_we and dm_we are never high in the same cycle.

## Timing
- Reset values: state=IDLE, addr=0, rw=0, cnt=0, sr_we=0, dm_we=0, miso_buf=0, busy=0.
- addr is valid 1 clk after LATCH.
- sr_we is asserted 2 clk after LATCH.
- dm_we is asserted 1 clk after the sclk_rise that carries the 8th data bit.
- Minimum spacing between sclk_rise pulses is 4 clk. The block's behaviour is undefined below that spacing.
- All outputs are registered. No output is combinational from an input.

## Configuration
- SPI_SEQ_AUTOINC_EN (burst mode) defined:
  - Instead of going to DONE, RD_SHIFT's 8th sclk_rise increments addr and → RD_WAIT.
  - WR_COMMIT increments addr and → WR_SHIFT.
  - addr wraps 127→0.
  - Bursts continue until cs goes high.
- SPI_SEQ_AUTOINC_EN undefined:
  - Exactly one byte per transaction; DONE is the terminal state.
  - addr changes only in LATCH.

## Structure
- The shared package spi_pkg holds:
  - the state enumeration (4-bit encoding: IDLE=0, CMD=1, LATCH=2, RD_WAIT=3, RD_LOAD=4, RD_SHIFT=5, WR_SHIFT=6, WR_COMMIT=7, DONE=8);
  - the ADDR_W/DATA_W defaults;
  - the RW bit index constant (0).
- One sub-module, spi_bit_counter, implements the 3-bit counter with clear, enable and a wrap-pulse output.

## Test plan
- Reset mid-RD_SHIFT (reset_n low for 1 clk) → all outputs are 0 and state=0 immediately, asynchronously.
- Read cmd 0x4B (addr 0x25, rw=1), memory[0x25]=0xA5:
  - addr=0x25 after LATCH;
  - one sr_we pulse;
  - miso_buf high for 8 sclk, then DONE;
  - 8 bits sampled as 0xA5.
- Write cmd 0x4A then data 0x3C → one dm_we pulse with addr=0x25 and sr_pdata=0x3C; memory[0x25]=0x3C.
- Write cmd then 5 data bits, then cs high → no dm_we, state=IDLE next clk, memory unchanged.
- Burst with SPI_SEQ_AUTOINC_EN: write at 0x7F, 2 data bytes 0x11, 0x22 → memory[0x7F]=0x11 and memory[0x00]=0x22 (wrap). Without the macro → only 0x7F is written and the second byte is ignored.
- cs rise coincident with the 8th data sclk_rise of a write → dm_we is never asserted, and state=IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory sequencer: state encoding, default widths, command bit layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  // Position of the R/W flag inside the command byte (1 = read).
  localparam int RW_BIT     = 0;

  // Encoding is fixed because state is exported to LEDs.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CMD       = 4'd1,
    LATCH     = 4'd2,
    RD_WAIT   = 4'd3,
    RD_LOAD   = 4'd4,
    RD_SHIFT  = 4'd5,
    WR_SHIFT  = 4'd6,
    WR_COMMIT = 4'd7,
    DONE      = 4'd8
  } state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// 3-bit SPI bit counter; wrap_o flags the increment that completes a byte (7 -> 0).
// Latency: count updates on the clk after en_i; wrap_o is combinational from en_i and the count.
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous clear,
//        en_i count enable (one per SCLK rise), wrap_o byte-boundary pulse.
module spi_bit_counter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = en_i && !clr_i && (cnt_q == 3'd7);

endmodule

// File: rtl/spi_mem_sequencer.sv
// SPI memory transaction sequencer: decodes the command byte, owns the address, strobes SR load / mem write.
// Latency: addr valid 1 clk after LATCH, sr_we 2 clk after LATCH, dm_we 1 clk after the 8th data SCLK rise.
// Backpressure: none; cs high aborts any transaction on the next clk and wins over a coincident sclk_rise.
// Ports: clk/reset_n clock and async active-low reset; cs, sclk_rise, sclk_fall, sr_pdata from the
//        SPI front end; addr, sr_we, dm_we, miso_buf, busy, state registered control outputs.
// Option: define SPI_SEQ_AUTOINC_EN for burst mode (address auto-increments, wraps at the top).
module spi_mem_sequencer
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic [DATA_W-1:0] sr_pdata,
  output logic [ADDR_W-1:0] addr,
  output logic              sr_we,
  output logic              dm_we,
  output logic              miso_buf,
  output logic              busy,
  output logic [3:0]        state
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic              sr_we_q;
  logic              dm_we_q;
  logic              miso_buf_q;
  logic              busy_q;

  logic cnt_clr;
  logic cnt_en;
  logic byte_done;

  // Counter is held clear while idle or while the master has deselected us.
  assign cnt_clr = cs || (state_q == IDLE);
  assign cnt_en  = sclk_rise &&
                   ((state_q == CMD) || (state_q == RD_SHIFT) || (state_q == WR_SHIFT));

  spi_bit_counter u_bit_counter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .wrap_o (byte_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      sr_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      miso_buf_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sr_we_q <= 1'b0;
      dm_we_q <= 1'b0;
      busy_q  <= 1'b1;
      if (cs) begin
        // Abort: checked first so a partial or just-completed write byte is never committed.
        state_q    <= IDLE;
        miso_buf_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE:    state_q <= CMD;
          CMD:     if (byte_done) state_q <= LATCH;
          LATCH: begin
            addr_q  <= sr_pdata[ADDR_W:1];
            rw_q    <= sr_pdata[RW_BIT];
            state_q <= sr_pdata[RW_BIT] ? RD_WAIT : WR_SHIFT;
          end
          RD_WAIT: begin
            // Memory read data is ready next clk; load the SR and start driving MISO then.
            state_q    <= RD_LOAD;
            sr_we_q    <= 1'b1;
            miso_buf_q <= 1'b1;
          end
          RD_LOAD: state_q <= RD_SHIFT;
          RD_SHIFT: begin
            if (byte_done) begin
`ifdef SPI_SEQ_AUTOINC_EN
              addr_q  <= addr_q + 1'b1;
              state_q <= RD_WAIT;
`else
              state_q <= DONE;
`endif
            end
          end
          WR_SHIFT: begin
            if (byte_done) begin
              state_q <= WR_COMMIT;
              dm_we_q <= 1'b1;
            end
          end
          WR_COMMIT: begin
`ifdef SPI_SEQ_AUTOINC_EN
            addr_q  <= addr_q + 1'b1;
            state_q <= WR_SHIFT;
`else
            state_q <= DONE;
`endif
          end
          DONE: begin
            // Last read bit stays on MISO until the master's following falling edge.
            if (sclk_fall && rw_q) miso_buf_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addr     = addr_q;
  assign sr_we    = sr_we_q;
  assign dm_we    = dm_we_q;
  assign miso_buf = miso_buf_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
